// File: rtl/pcap_replay_pacer_pkg.sv
// rtl/pcap_replay_pacer_pkg.sv - shared state encoding and tuser field offsets for the replay pacer
package pcap_replay_pacer_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_GAP  = 2'd1,
    ST_SEND = 2'd2
  } pacer_state_t;

  localparam int LEN_POS  = 0;
  localparam int PORT_POS = 16;
  localparam int GAP_POS  = 32;
  localparam int GAP_W    = 32;

endpackage

// File: rtl/pcap_replay_pacer_slice.sv
// rtl/pcap_replay_pacer_slice.sv - 2-entry AXIS register slice; ready while any entry is free
module axis_reg_slice #(
  parameter int DATA_W = 512,
  parameter int KEEP_W = 64,
  parameter int USER_W = 128
) (
  input  logic              axis_aclk,
  input  logic              axis_reset,
  input  logic [DATA_W-1:0] s_axis_tdata,
  input  logic [KEEP_W-1:0] s_axis_tkeep,
  input  logic [USER_W-1:0] s_axis_tuser,
  input  logic              s_axis_tvalid,
  output logic              s_axis_tready,
  input  logic              s_axis_tlast,
  output logic [DATA_W-1:0] m_axis_tdata,
  output logic [KEEP_W-1:0] m_axis_tkeep,
  output logic [USER_W-1:0] m_axis_tuser,
  output logic              m_axis_tvalid,
  input  logic              m_axis_tready,
  output logic              m_axis_tlast
);

  localparam int W = DATA_W + KEEP_W + USER_W + 1;

  logic [W-1:0] mem [2];
  logic [1:0]   count;
  logic         wr_ptr;
  logic         rd_ptr;
  logic         s_hs;
  logic         m_hs;

  assign s_axis_tready = (count != 2'd2);
  assign m_axis_tvalid = (count != 2'd0);
  assign s_hs          = s_axis_tvalid && s_axis_tready;
  assign m_hs          = m_axis_tvalid && m_axis_tready;

  assign {m_axis_tdata, m_axis_tkeep, m_axis_tuser, m_axis_tlast} = mem[rd_ptr];

  // Payload storage carries no reset; occupancy alone decides validity.
  always_ff @(posedge axis_aclk) begin
    if (s_hs) begin
      mem[wr_ptr] <= {s_axis_tdata, s_axis_tkeep, s_axis_tuser, s_axis_tlast};
    end
  end

  always_ff @(posedge axis_aclk) begin
    if (axis_reset) begin
      count  <= 2'd0;
      wr_ptr <= 1'b0;
      rd_ptr <= 1'b0;
    end else begin
      if (s_hs) begin
        wr_ptr <= ~wr_ptr;
      end
      if (m_hs) begin
        rd_ptr <= ~rd_ptr;
      end
      count <= count + {1'b0, s_hs} - {1'b0, m_hs};
    end
  end

endmodule

// File: rtl/pcap_replay_pacer.sv
// rtl/pcap_replay_pacer.sv - releases stored pcap packets with per-packet inter-packet gaps
module pcap_replay_pacer
  import pcap_replay_pacer_pkg::*;
#(
  parameter int C_M_AXIS_DATA_WIDTH  = 512,
  parameter int C_S_AXIS_DATA_WIDTH  = 512,
  parameter int C_M_AXIS_TUSER_WIDTH = 128,
  parameter int C_S_AXIS_TUSER_WIDTH = 128,
  parameter int C_GAP_WIDTH          = 32
) (
  input  logic                              axis_aclk,
  input  logic                              axis_reset,
  input  logic [C_S_AXIS_DATA_WIDTH-1:0]    s_axis_tdata,
  input  logic [C_S_AXIS_DATA_WIDTH/8-1:0]  s_axis_tkeep,
  input  logic [C_S_AXIS_TUSER_WIDTH-1:0]   s_axis_tuser,
  input  logic                              s_axis_tvalid,
  output logic                              s_axis_tready,
  input  logic                              s_axis_tlast,
  output logic [C_M_AXIS_DATA_WIDTH-1:0]    m_axis_tdata,
  output logic [C_M_AXIS_DATA_WIDTH/8-1:0]  m_axis_tkeep,
  output logic [C_M_AXIS_TUSER_WIDTH-1:0]   m_axis_tuser,
  output logic                              m_axis_tvalid,
  input  logic                              m_axis_tready,
  output logic                              m_axis_tlast,
  input  logic                              pacer_en,
  input  logic                              stats_clear,
  output logic [31:0]                       pkt_count,
  output logic [31:0]                       late_count
);

  localparam logic [C_GAP_WIDTH-1:0] ELAPSED_MAX = '1;
  localparam logic [C_GAP_WIDTH-1:0] GAP_ONE     = {{(C_GAP_WIDTH-1){1'b0}}, 1'b1};
  localparam logic [C_GAP_WIDTH:0]   WIDE_ONE    = {{C_GAP_WIDTH{1'b0}}, 1'b1};

  pacer_state_t state;
  pacer_state_t state_d;

  logic [C_GAP_WIDTH-1:0]          elapsed;
  logic [C_GAP_WIDTH-1:0]          gap_q;
  logic                            first_pkt;
  logic                            sop_pending;
  logic                            pacer_en_q;
  logic                            slice_ready;
  logic                            slice_valid;
  logic                            in_hs;
  logic                            sop_hs;
  logic                            release_gap;
  logic                            is_late;
  logic [C_S_AXIS_TUSER_WIDTH-1:0] tuser_stripped;

  assign slice_valid   = s_axis_tvalid && (state == ST_SEND);
  assign s_axis_tready = (state == ST_SEND) && slice_ready;
  assign in_hs         = s_axis_tvalid && s_axis_tready;
  assign sop_hs        = in_hs && sop_pending;

  // GAP is left one cycle before elapsed reaches the gap, so SOP-to-SOP lands on gap+1.
  assign release_gap = first_pkt || !pacer_en ||
                       (({1'b0, elapsed} + WIDE_ONE) >= {1'b0, gap_q});

  // A zero gap requests no spacing at all, so such a packet is never counted late.
  assign is_late = pacer_en && !first_pkt && (gap_q != '0) &&
                   ({1'b0, elapsed} > ({1'b0, gap_q} + WIDE_ONE));

  always_comb begin
    tuser_stripped = s_axis_tuser;
    tuser_stripped[GAP_POS +: C_GAP_WIDTH] = '0;
  end

  always_comb begin
    state_d = state;
    case (state)
      ST_IDLE: if (s_axis_tvalid) state_d = ST_GAP;
      ST_GAP:  if (release_gap) state_d = ST_SEND;
      ST_SEND: if (in_hs && s_axis_tlast) state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge axis_aclk) begin
    if (axis_reset) begin
      state       <= ST_IDLE;
      elapsed     <= '0;
      gap_q       <= '0;
      first_pkt   <= 1'b1;
      sop_pending <= 1'b1;
      pacer_en_q  <= 1'b0;
      pkt_count   <= 32'd0;
      late_count  <= 32'd0;
    end else begin
      state      <= state_d;
      pacer_en_q <= pacer_en;

      if (state == ST_IDLE && s_axis_tvalid) begin
        gap_q <= s_axis_tuser[GAP_POS +: C_GAP_WIDTH];
      end

      if (sop_hs) begin
        elapsed <= '0;
      end else if (elapsed != ELAPSED_MAX) begin
        elapsed <= elapsed + GAP_ONE;
      end

      // Re-enabling the pacer must not apply a gap measured while it was off.
      if (pacer_en && !pacer_en_q) begin
        first_pkt <= 1'b1;
      end else if (sop_hs) begin
        first_pkt <= 1'b0;
      end

      if (state != ST_SEND) begin
        sop_pending <= 1'b1;
      end else if (in_hs) begin
        sop_pending <= 1'b0;
      end

      if (stats_clear) begin
        pkt_count <= 32'd0;
      end else if (sop_hs) begin
        pkt_count <= pkt_count + 32'd1;
      end

      if (stats_clear) begin
        late_count <= 32'd0;
      end else if (sop_hs && is_late) begin
        late_count <= late_count + 32'd1;
      end
    end
  end

  axis_reg_slice #(
    .DATA_W (C_M_AXIS_DATA_WIDTH),
    .KEEP_W (C_M_AXIS_DATA_WIDTH/8),
    .USER_W (C_M_AXIS_TUSER_WIDTH)
  ) u_slice (
    .axis_aclk     (axis_aclk),
    .axis_reset    (axis_reset),
    .s_axis_tdata  (s_axis_tdata),
    .s_axis_tkeep  (s_axis_tkeep),
    .s_axis_tuser  (tuser_stripped),
    .s_axis_tvalid (slice_valid),
    .s_axis_tready (slice_ready),
    .s_axis_tlast  (s_axis_tlast),
    .m_axis_tdata  (m_axis_tdata),
    .m_axis_tkeep  (m_axis_tkeep),
    .m_axis_tuser  (m_axis_tuser),
    .m_axis_tvalid (m_axis_tvalid),
    .m_axis_tready (m_axis_tready),
    .m_axis_tlast  (m_axis_tlast)
  );

endmodule

// File: tb/tb_pcap_replay_pacer.sv
// tb/tb_pcap_replay_pacer.sv - self-checking bench for pcap_replay_pacer against a spacing/scoreboard model
module tb_pcap_replay_pacer;

  typedef struct {
    logic [511:0] d;
    logic [63:0]  k;
    logic [127:0] u;
    logic         l;
  } beat_t;

  logic         axis_aclk = 1'b0;
  logic         axis_reset = 1'b1;
  logic [511:0] s_axis_tdata = '0;
  logic [63:0]  s_axis_tkeep = '0;
  logic [127:0] s_axis_tuser = '0;
  logic         s_axis_tvalid = 1'b0;
  logic         s_axis_tready;
  logic         s_axis_tlast = 1'b0;
  logic [511:0] m_axis_tdata;
  logic [63:0]  m_axis_tkeep;
  logic [127:0] m_axis_tuser;
  logic         m_axis_tvalid;
  logic         m_axis_tready;
  logic         m_axis_tlast;
  logic         pacer_en = 1'b1;
  logic         stats_clear = 1'b0;
  logic [31:0]  pkt_count;
  logic [31:0]  late_count;

  logic  toggle_mode = 1'b0;
  logic  tog = 1'b0;
  int    cyc = 0;
  int    checks = 0;
  int    errors = 0;
  int    beats_out = 0;
  int    present_cyc = 0;
  logic  out_mid = 1'b0;
  beat_t exp_q[$];
  int    sop_q[$];

  assign m_axis_tready = toggle_mode ? tog : 1'b1;

  always #5 axis_aclk = ~axis_aclk;

  always @(posedge axis_aclk) begin
    cyc <= cyc + 1;
    tog <= ~tog;
  end

  pcap_replay_pacer dut (
    .axis_aclk     (axis_aclk),
    .axis_reset    (axis_reset),
    .s_axis_tdata  (s_axis_tdata),
    .s_axis_tkeep  (s_axis_tkeep),
    .s_axis_tuser  (s_axis_tuser),
    .s_axis_tvalid (s_axis_tvalid),
    .s_axis_tready (s_axis_tready),
    .s_axis_tlast  (s_axis_tlast),
    .m_axis_tdata  (m_axis_tdata),
    .m_axis_tkeep  (m_axis_tkeep),
    .m_axis_tuser  (m_axis_tuser),
    .m_axis_tvalid (m_axis_tvalid),
    .m_axis_tready (m_axis_tready),
    .m_axis_tlast  (m_axis_tlast),
    .pacer_en      (pacer_en),
    .stats_clear   (stats_clear),
    .pkt_count     (pkt_count),
    .late_count    (late_count)
  );

  task automatic check(input string tag, input logic [511:0] got, input logic [511:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Output scoreboard: every delivered beat must match the next accepted input beat.
  always @(negedge axis_aclk) begin
    if (axis_reset) begin
      out_mid = 1'b0;
    end else if (m_axis_tvalid && m_axis_tready) begin
      beat_t e;
      beats_out++;
      if (exp_q.size() == 0) begin
        check("spurious_beat_q", exp_q.size(), 1);
      end else begin
        e = exp_q.pop_front();
        check("out_tdata", m_axis_tdata, e.d);
        check("out_tkeep", m_axis_tkeep, e.k);
        check("out_tuser", m_axis_tuser, e.u);
        check("out_tlast", m_axis_tlast, e.l);
      end
      if (!out_mid) sop_q.push_back(cyc);
      out_mid = !m_axis_tlast;
    end
  end

  task automatic drive_beat(input logic [511:0] d, input logic [63:0] k,
                            input logic [127:0] u, input logic l);
    beat_t e;
    int n;
    s_axis_tdata  = d;
    s_axis_tkeep  = k;
    s_axis_tuser  = u;
    s_axis_tlast  = l;
    s_axis_tvalid = 1'b1;
    n = 0;
    forever begin
      @(negedge axis_aclk);
      if (s_axis_tready) break;
      n++;
      if (n > 1000) begin
        check("in_hs_timeout", s_axis_tready, 1);
        break;
      end
    end
    if (s_axis_tready) begin
      e.d = d; e.k = k; e.u = u; e.l = l;
      e.u[32 +: 32] = '0;
      exp_q.push_back(e);
    end
    @(posedge axis_aclk);
    #1;
    s_axis_tvalid = 1'b0;
  endtask

  task automatic rand_beat(output logic [511:0] d, output logic [63:0] k);
    for (int w = 0; w < 16; w++) d[w*32 +: 32] = $urandom;
    k = {$urandom, $urandom};
  endtask

  task automatic make_user(input logic [31:0] gap, output logic [127:0] u);
    for (int i = 0; i < 4; i++) u[i*32 +: 32] = $urandom;
    u[32 +: 32] = gap;
  endtask

  task automatic send_pkt(input int beats, input logic [31:0] gap);
    logic [127:0] u;
    logic [511:0] d;
    logic [63:0]  k;
    make_user(gap, u);
    present_cyc = cyc;
    for (int b = 0; b < beats; b++) begin
      rand_beat(d, k);
      drive_beat(d, k, u, b == beats - 1);
    end
  endtask

  task automatic do_reset();
    axis_reset    = 1'b1;
    s_axis_tvalid = 1'b0;
    repeat (3) @(posedge axis_aclk);
    #1;
    axis_reset = 1'b0;
    exp_q.delete();
    sop_q.delete();
  endtask

  task automatic wait_drain(input int n);
    int t;
    t = 0;
    while ((exp_q.size() != 0 || sop_q.size() < n) && t < 5000) begin
      @(negedge axis_aclk);
      t++;
    end
    check("drain_pkts", sop_q.size(), n);
    check("drain_beats", exp_q.size(), 0);
    @(posedge axis_aclk);
    #1;
  endtask

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "watchdog");
  end

  initial begin
    int bts[12];
    int gps[12];
    int sp;
    int late_exp;
    int b0;
    int target;
    logic [511:0] d;
    logic [63:0]  k;
    logic [127:0] u;

    // Reset state
    do_reset();
    check("rst_m_tvalid", m_axis_tvalid, 0);
    check("rst_s_tready", s_axis_tready, 0);
    check("rst_pkt_count", pkt_count, 0);
    check("rst_late_count", late_count, 0);

    // Three back-to-back 4-beat packets with zero gap
    for (int i = 0; i < 3; i++) send_pkt(4, 32'd0);
    wait_drain(3);
    if (sop_q.size() >= 3) begin
      check("zero_gap_sp1", sop_q[1] - sop_q[0], 6);
      check("zero_gap_sp2", sop_q[2] - sop_q[1], 6);
    end
    check("zero_gap_pkt", pkt_count, 3);
    check("zero_gap_late", late_count, 0);
    stats_clear = 1'b1;
    @(posedge axis_aclk);
    #1;
    stats_clear = 1'b0;
    check("stats_clear_pkt", pkt_count, 0);

    // Gap of 100 between two single-beat packets
    do_reset();
    send_pkt(1, $urandom);
    send_pkt(1, 32'd100);
    wait_drain(2);
    if (sop_q.size() >= 2) check("gap100_sp", sop_q[1] - sop_q[0], 101);
    check("gap100_pkt", pkt_count, 2);
    check("gap100_late", late_count, 0);

    // Same traffic with the pacer disabled
    pacer_en = 1'b0;
    do_reset();
    send_pkt(1, $urandom);
    send_pkt(1, 32'd100);
    wait_drain(2);
    if (sop_q.size() >= 2) check("bypass_sp", sop_q[1] - sop_q[0], 3);
    check("bypass_pkt", pkt_count, 2);
    pacer_en = 1'b1;

    // Upstream presents late: released without waiting, counted late
    do_reset();
    send_pkt(1, $urandom_range(0, 1000));
    wait_drain(1);
    if (sop_q.size() >= 1) begin
      target = sop_q[0] - 1 + 50;
      while (cyc < target) begin
        @(posedge axis_aclk);
        #1;
      end
    end
    send_pkt(1, 32'd10);
    wait_drain(2);
    if (sop_q.size() >= 2) check("late_release", sop_q[1] - present_cyc, 3);
    check("late_count", late_count, 1);
    check("late_pkt", pkt_count, 2);

    // Output backpressure toggling every cycle over an 8-beat packet
    do_reset();
    toggle_mode = 1'b1;
    b0 = beats_out;
    send_pkt(8, 32'd0);
    wait_drain(1);
    check("bp_beats", beats_out - b0, 8);
    check("bp_pkt", pkt_count, 1);
    toggle_mode = 1'b0;

    // Reset in the middle of a packet, then a clean packet
    do_reset();
    make_user(32'd0, u);
    for (int b = 0; b < 2; b++) begin
      rand_beat(d, k);
      drive_beat(d, k, u, 1'b0);
    end
    do_reset();
    check("midrst_m_tvalid", m_axis_tvalid, 0);
    check("midrst_pkt", pkt_count, 0);
    send_pkt(2, 32'd500);
    wait_drain(1);
    if (sop_q.size() >= 1) check("midrst_release", sop_q[0] - present_cyc, 3);
    check("midrst_pkt_after", pkt_count, 1);

    // Randomised packets against the spacing rule max(gap+1, prev_beats+2)
    do_reset();
    for (int i = 0; i < 12; i++) begin
      bts[i] = $urandom_range(1, 6);
      gps[i] = ($urandom_range(0, 3) == 0) ? 0 : $urandom_range(1, 20);
    end
    for (int i = 0; i < 12; i++) send_pkt(bts[i], gps[i]);
    wait_drain(12);
    late_exp = 0;
    for (int i = 1; i < 12; i++) begin
      sp = (gps[i] + 1 > bts[i-1] + 2) ? gps[i] + 1 : bts[i-1] + 2;
      // elapsed at a SOP is one less than the SOP-to-SOP spacing
      if (gps[i] != 0 && sp - 1 > gps[i] + 1) late_exp++;
      if (sop_q.size() >= 12) check($sformatf("rand_sp%0d", i), sop_q[i] - sop_q[i-1], sp);
    end
    check("rand_pkt", pkt_count, 12);
    check("rand_late", late_count, late_exp);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
